// File: rtl/ex_stage_mc.sv
// ex_stage_mc: registered MIPS I execute stage with valid/ready handshakes on
// both sides. It resolves ALU ops, shifts, LUI and branches/jumps in one cycle.
// Define EX_MULDIV_EN to build the iterative MULT/DIV unit with HI/LO and MFHI/MFLO.
// Without that macro, MD ops and MFHI/MFLO complete in one cycle with Result=0.
module ex_stage_mc #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MD_BITS = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Ins,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    input  logic [XLEN-1:0] Ed32,
    input  logic [XLEN-1:0] nextPC,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic [XLEN-1:0] newPC,
    output logic            taken,
    output logic            ovf,
    output logic            busy
);
    logic [5:0]      op, fn;
    logic [4:0]      shamt;
    logic [XLEN-1:0] zimm, lui_val, add_s, sub_s, addi_s, br_tgt, j_tgt;
    logic [XLEN-1:0] res, npc, result_q, newpc_q;
    logic            tk, of, taken_q, ovf_q, out_valid_q, out_valid_d, accept;

    assign op      = Ins[31:26];
    assign fn      = Ins[5:0];
    assign shamt   = Ins[10:6];
    assign zimm    = XLEN'(Ins[15:0]);
    assign lui_val = XLEN'($signed({Ins[15:0], 16'h0000}));
    assign add_s   = Rdata1 + Rdata2;
    assign sub_s   = Rdata1 - Rdata2;
    assign addi_s  = Rdata1 + Ed32;
    assign br_tgt  = nextPC + (Ed32 << 2);
    assign j_tgt   = {nextPC[XLEN-1:28], Ins[25:0], 2'b00};
    assign accept  = in_valid && in_ready;

`ifdef EX_MULDIV_EN
    localparam logic [1:0]  StIdle  = 2'd0;
    localparam logic [1:0]  StBusy  = 2'd1;
    localparam logic [1:0]  StDone  = 2'd2;
    localparam int unsigned MdSteps = XLEN / MD_BITS;
    localparam int unsigned CntW    = (MdSteps > 1) ? $clog2(MdSteps) : 1;

    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    // acc: partial product high half / remainder; wrk: multiplier / quotient
    logic [XLEN-1:0]     acc_q, acc_d, wrk_q, wrk_d, opa_q, opa_d, hi_q, hi_d, lo_q, lo_d;
    logic                div_q, div_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
    logic                is_md, md_div, md_sgn, rs_neg, rt_neg;
    logic [XLEN-1:0]     mag1, mag2, acc_n, wrk_n, hi_fix, lo_fix;
    logic [XLEN:0]       trial;
    logic [XLEN+MD_BITS-1:0]   psum;
    logic [2*XLEN+MD_BITS-1:0] shf;
    logic [2*XLEN-1:0]   prod;

    assign md_div   = Ins[1];
    assign md_sgn   = ~Ins[0];
    assign rs_neg   = md_sgn & Rdata1[XLEN-1];
    assign rt_neg   = md_sgn & Rdata2[XLEN-1];
    assign mag1     = rs_neg ? -Rdata1 : Rdata1;
    assign mag2     = rt_neg ? -Rdata2 : Rdata2;
    assign busy     = (state_q == StBusy);
    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);

    // One iteration step: MD_BITS restoring-divide or shift-add multiply bits
    always_comb begin
        acc_n = acc_q;
        wrk_n = wrk_q;
        trial = '0;
        psum  = '0;
        shf   = '0;
        if (div_q) begin
            for (int k = 0; k < int'(MD_BITS); k++) begin
                trial = {acc_n, wrk_n[XLEN-1]};
                wrk_n = {wrk_n[XLEN-2:0], 1'b0};
                if (trial >= {1'b0, opa_q}) begin
                    trial    = trial - {1'b0, opa_q};
                    wrk_n[0] = 1'b1;
                end
                acc_n = trial[XLEN-1:0];
            end
        end else begin
            psum  = (XLEN+MD_BITS)'(acc_q)
                  + (XLEN+MD_BITS)'(opa_q) * (XLEN+MD_BITS)'(wrk_q[MD_BITS-1:0]);
            shf   = {psum, wrk_q} >> MD_BITS;
            acc_n = shf[2*XLEN-1:XLEN];
            wrk_n = shf[XLEN-1:0];
        end
    end

    // Sign fix-up of magnitudes on completion; remainder follows the dividend
    always_comb begin
        prod = negq_q ? -{acc_q, wrk_q} : {acc_q, wrk_q};
        if (div_q) begin
            hi_fix = negr_q ? -acc_q : acc_q;
            lo_fix = dz_q ? '1 : (negq_q ? -wrk_q : wrk_q);
        end else begin
            hi_fix = prod[2*XLEN-1:XLEN];
            lo_fix = prod[XLEN-1:0];
        end
    end

    // MD sequencer next state: IDLE -> BUSY (MdSteps cycles) -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        opa_d   = opa_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: if (accept && is_md) begin
                state_d = StBusy;
                cnt_d   = CntW'(MdSteps - 1);
                acc_d   = '0;
                div_d   = md_div;
                negq_d  = rs_neg ^ rt_neg;
                negr_d  = rs_neg;
                dz_d    = (Rdata2 == '0);
                opa_d   = md_div ? mag2 : mag1;
                wrk_d   = md_div ? mag1 : mag2;
            end
            StBusy: begin
                acc_d = acc_n;
                wrk_d = wrk_n;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) state_d = StDone;
            end
            StDone: begin
                hi_d    = hi_fix;
                lo_d    = lo_fix;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // MD state and HI/LO registers; reset aborts any operation in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            wrk_q   <= '0;
            opa_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            opa_q   <= opa_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
`else
    assign busy     = 1'b0;
    assign in_ready = !out_valid_q || out_ready;
`endif

    // Decode and compute the single-cycle result, next PC and flags
    always_comb begin
        res = '0;
        npc = nextPC;
        tk  = 1'b0;
        of  = 1'b0;
`ifdef EX_MULDIV_EN
        is_md = 1'b0;
`endif
        case (op)
            6'h00: case (fn)
                6'h00: res = Rdata2 << shamt;
                6'h02: res = Rdata2 >> shamt;
                6'h03: res = $signed(Rdata2) >>> shamt;
                6'h08: begin npc = Rdata1; tk = 1'b1; end
                6'h09: begin npc = Rdata1; tk = 1'b1; res = nextPC; end
`ifdef EX_MULDIV_EN
                6'h10: res = hi_q;
                6'h12: res = lo_q;
                6'h18, 6'h19, 6'h1A, 6'h1B: is_md = 1'b1;
`endif
                6'h20: begin
                    res = add_s;
                    of  = (Rdata1[XLEN-1] == Rdata2[XLEN-1]) && (add_s[XLEN-1] != Rdata1[XLEN-1]);
                end
                6'h21: res = add_s;
                6'h22: begin
                    res = sub_s;
                    of  = (Rdata1[XLEN-1] != Rdata2[XLEN-1]) && (sub_s[XLEN-1] != Rdata1[XLEN-1]);
                end
                6'h23: res = sub_s;
                6'h24: res = Rdata1 & Rdata2;
                6'h25: res = Rdata1 | Rdata2;
                6'h26: res = Rdata1 ^ Rdata2;
                6'h27: res = ~(Rdata1 | Rdata2);
                6'h2A: res = XLEN'($signed(Rdata1) < $signed(Rdata2));
                6'h2B: res = XLEN'(Rdata1 < Rdata2);
                default: res = '0;
            endcase
            6'h02: begin npc = j_tgt; tk = 1'b1; end
            6'h03: begin npc = j_tgt; tk = 1'b1; res = nextPC; end
            6'h04: if (Rdata1 == Rdata2) begin npc = br_tgt; tk = 1'b1; end
            6'h05: if (Rdata1 != Rdata2) begin npc = br_tgt; tk = 1'b1; end
            6'h08: begin
                res = addi_s;
                of  = (Rdata1[XLEN-1] == Ed32[XLEN-1]) && (addi_s[XLEN-1] != Rdata1[XLEN-1]);
            end
            6'h09: res = addi_s;
            6'h0A: res = XLEN'($signed(Rdata1) < $signed(Ed32));
            6'h0B: res = XLEN'(Rdata1 < Ed32);
            6'h0C: res = Rdata1 & zimm;
            6'h0D: res = Rdata1 | zimm;
            6'h0E: res = Rdata1 ^ zimm;
            6'h0F: res = lui_val;
            default: res = '0;
        endcase
    end

    // Output beat valid: set by a single-cycle accept or MD completion, cleared when taken
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
`ifdef EX_MULDIV_EN
        if (accept && !is_md) out_valid_d = 1'b1;
        if (state_q == StDone) out_valid_d = 1'b1;
`else
        if (accept) out_valid_d = 1'b1;
`endif
    end

    // Output registers load on accept and hold while MEM back-pressures
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            newpc_q     <= '0;
            taken_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                result_q <= res;
                newpc_q  <= npc;
                taken_q  <= tk;
                ovf_q    <= of;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign newPC     = newpc_q;
    assign taken     = taken_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed self-checking bench for ex_stage_mc (XLEN=32, MD_BITS=1).
// MD checks are built when EX_MULDIV_EN is defined, else the 1-cycle stub is checked.
module tb_ex_stage_mc;
    logic        CLK = 1'b0;
    logic        RST, in_valid, in_ready, out_valid, out_ready, taken, ovf, busy;
    logic [31:0] Ins, Rdata1, Rdata2, Ed32, nextPC, Result, newPC;
    int          n_chk = 0;
    int          n_bad = 0;

    ex_stage_mc #(.XLEN(32), .MD_BITS(1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .Ins(Ins),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32), .nextPC(nextPC),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .newPC(newPC),
        .taken(taken), .ovf(ovf), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sa);
        return {6'h00, 5'd1, 5'd2, 5'd3, sa, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Present one instruction, wait (bounded) for in_ready, then pass the accepting edge
    task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] ed, input logic [31:0] npc);
        int w = 0;
        Ins = ins; Rdata1 = r1; Rdata2 = r2; Ed32 = ed; nextPC = npc;
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < 100) begin
            @(posedge CLK); #1;
            w++;
        end
        if (w >= 100) check("ready_timeout", 0, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

`ifdef EX_MULDIV_EN
    // Count busy cycles after an MD accept, then expect the completion beat
    task automatic md_wait(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check({tag, "_busy_cycles"}, n, 32);
        @(posedge CLK); #1;
        check({tag, "_done_valid"}, out_valid, 1);
        check({tag, "_done_result"}, Result, 0);
    endtask
`endif

    initial begin
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Ins = '0; Rdata1 = '0; Rdata2 = '0; Ed32 = '0; nextPC = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_result", Result, 0);
        check("rst_newpc", newPC, 0);
        check("rst_flags", {taken, ovf, busy}, 3'b000);
        RST = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);

        send(rtype(6'h20, 0), 32'h7FFF_FFFF, 32'h1, 0, 32'h40);
        check("add_valid", out_valid, 1);
        check("add_result", Result, 32'h8000_0000);
        check("add_ovf", ovf, 1);
        check("add_taken", taken, 0);
        check("add_newpc", newPC, 32'h40);

        send(rtype(6'h22, 0), 32'd5, 32'd7, 0, 32'h44);
        check("sub_result", Result, 32'hFFFF_FFFE);
        check("sub_ovf", ovf, 0);

        send(rtype(6'h21, 0), 32'h7FFF_FFFF, 32'h1, 0, 32'h48);
        check("addu_ovf", ovf, 0);

        send(itype(6'h04, 16'hFFFE), 32'd5, 32'd5, 32'hFFFF_FFFE, 32'h100);
        check("beq_newpc", newPC, 32'hF8);
        check("beq_taken", taken, 1);

        send(itype(6'h05, 16'hFFFE), 32'd5, 32'd5, 32'hFFFF_FFFE, 32'h100);
        check("bne_newpc", newPC, 32'h100);
        check("bne_taken", taken, 0);

        send({6'h03, 26'h000_0040}, 0, 0, 0, 32'h1000_0004);
        check("jal_newpc", newPC, 32'h1000_0100);
        check("jal_result", Result, 32'h1000_0004);
        check("jal_taken", taken, 1);

        send(rtype(6'h08, 0), 32'h2000, 0, 0, 32'h50);
        check("jr_newpc", newPC, 32'h2000);

        send(rtype(6'h03, 5'd4), 0, 32'h8000_0000, 0, 32'h54);
        check("sra_result", Result, 32'hF800_0000);

        send(itype(6'h0F, 16'h8001), 0, 0, 32'hFFFF_8001, 32'h58);
        check("lui_result", Result, 32'h8001_0000);

        send(itype(6'h0D, 16'h8001), 32'hF000_0000, 0, 32'hFFFF_8001, 32'h5C);
        check("ori_result", Result, 32'hF000_8001);

        send(rtype(6'h2A, 0), 32'hFFFF_FFFF, 32'h1, 0, 32'h60);
        check("slt_result", Result, 1);

        send(itype(6'h08, 16'hFFFF), 32'h8000_0000, 0, 32'hFFFF_FFFF, 32'h64);
        check("addi_ovf", ovf, 1);
        check("addi_result", Result, 32'h7FFF_FFFF);

        send(32'hFC00_0000, 32'h11, 32'h22, 32'h33, 32'h68);
        check("unk_result", Result, 0);
        check("unk_newpc", newPC, 32'h68);
        check("unk_taken", taken, 0);

        // Back-pressure: SLTU beat held for 3 cycles while ADDU waits
        @(posedge CLK); #1;
        check("idle_valid", out_valid, 0);
        out_ready = 1'b0;
        send(rtype(6'h2B, 0), 32'h1, 32'h2, 0, 32'h70);
        Ins = rtype(6'h21, 0); Rdata1 = 32'd3; Rdata2 = 32'd4; nextPC = 32'h74;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_result", Result, 1);
            @(posedge CLK); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check("bp_next_result", Result, 7);
        check("bp_next_valid", out_valid, 1);

`ifdef EX_MULDIV_EN
        send(rtype(6'h1A, 0), 32'hFFFF_FFF9, 32'd2, 0, 32'h80);
        check("div_busy", busy, 1);
        check("div_ready", in_ready, 0);
        check("div_novalid", out_valid, 0);
        md_wait("div");
        check("div_newpc", newPC, 32'h80);
        send(rtype(6'h12, 0), 0, 0, 0, 32'h84);
        check("div_lo", Result, 32'hFFFF_FFFD);
        send(rtype(6'h10, 0), 0, 0, 0, 32'h88);
        check("div_hi", Result, 32'hFFFF_FFFF);

        send(rtype(6'h1B, 0), 32'h0000_1234, 32'd0, 0, 32'h90);
        md_wait("divu0");
        send(rtype(6'h12, 0), 0, 0, 0, 32'h94);
        check("divu0_lo", Result, 32'hFFFF_FFFF);
        send(rtype(6'h10, 0), 0, 0, 0, 32'h98);
        check("divu0_hi", Result, 32'h0000_1234);

        send(rtype(6'h18, 0), 32'd3, 32'hFFFF_FFFB, 0, 32'hA0);
        md_wait("mult");
        send(rtype(6'h12, 0), 0, 0, 0, 32'hA4);
        check("mult_lo", Result, 32'hFFFF_FFF1);
        send(rtype(6'h10, 0), 0, 0, 0, 32'hA8);
        check("mult_hi", Result, 32'hFFFF_FFFF);

        send(rtype(6'h19, 0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hB0);
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        check("abort_no_beat", out_valid, 0);
        send(rtype(6'h10, 0), 0, 0, 0, 32'hB4);
        check("abort_hi", Result, 0);
`else
        send(rtype(6'h1A, 0), 32'hFFFF_FFF9, 32'd2, 0, 32'h80);
        check("div_stub_valid", out_valid, 1);
        check("div_stub_result", Result, 0);
        check("div_stub_busy", busy, 0);
        check("div_stub_newpc", newPC, 32'h80);
        send(rtype(6'h10, 0), 32'h55, 32'h66, 0, 32'h84);
        check("mfhi_stub", Result, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
